dmem_store_buffer: RTL and testbench

- Data-memory stage directly downstream of the pipelined core's Memory stage. It consumes the core's memory outputs: ALU result as the address, write data, and the memory write enable.
- Contains a word-addressed backing RAM whose writes take WRITE_LAT cycles.
- Stores go into a FIFO store buffer and drain to RAM in the background.
- Loads return data the same cycle, forwarded from the youngest matching buffered store, otherwise read from RAM.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_store_buffer_sb_fifo.sv | 85 ++++++++
 rtl/dmem_store_buffer.sv | 130 +++++++++++++
 tb/tb_dmem_store_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
package dmem_pkg;

  // Index field is sized for the widest meaningful word index of a 32-bit
  // byte address. Narrower RAMs zero-extend into it; the constant upper bits
  // are trimmed by synthesis.
  localparam int SB_INDEX_W = 30;

  // Default RAM write latency, and the latency-counter width it implies.
  localparam int DEFAULT_WRITE_LAT = 2;
  localparam int DRAIN_CNT_W       = $clog2(DEFAULT_WRITE_LAT) + 1;

  // One buffered store: target word index and the word to write.
  typedef struct packed {
    logic [SB_INDEX_W-1:0] index;
    logic [31:0]           data;
  } sb_entry_t;

  // Drain engine: waiting for work, or holding the RAM port for a write.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

  // Latency-counter width for an arbitrary write latency.
  function automatic int drain_cnt_w(input int write_lat);
    return $clog2(write_lat) + 1;
  endfunction

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// Circular store buffer with a same-cycle youngest-match lookup used for
// load forwarding. Push acceptance is decided by the parent.
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic [SB_INDEX_W-1:0]   i_push_index,
  input  logic [31:0]             i_push_data,
  input  logic                    i_pop,
  input  logic [SB_INDEX_W-1:0]   i_lookup_index,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [SB_INDEX_W-1:0]   o_head_index,
  output logic [31:0]             o_head_data,
  output logic                    o_hit,
  output logic [31:0]             o_hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  // Per-slot view ordered by age: slot 0 is the head (oldest).
  logic [PTR_W-1:0]    w_slot_ptr  [DEPTH];
  logic [31:0]         w_slot_data [DEPTH];
  logic [DEPTH-1:0]    w_slot_match;

  // Entry storage: written at the tail on an accepted push; not reset.
  always_ff @(posedge clk) begin
    if (!i_rst && i_push) begin
      r_mem[r_tail] <= '{index: i_push_index, data: i_push_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_slot_ptr[gi]   = r_head + PTR_W'(gi);
      assign w_slot_data[gi]  = r_mem[w_slot_ptr[gi]].data;
      assign w_slot_match[gi] = (CNT_W'(gi) < r_count) &&
                                (r_mem[w_slot_ptr[gi]].index == i_lookup_index);
    end
  endgenerate

  // Youngest match wins: scan oldest to youngest so later hits override.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_slot_match[k]) begin
        o_hit      = 1'b1;
        o_hit_data = w_slot_data[k];
      end
    end
  end

  assign o_count      = r_count;
  assign o_head_index = r_mem[r_head].index;
  assign o_head_data  = r_mem[r_head].data;

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory stage: stores are buffered and drained to a slow-write RAM in
// the background; loads see buffered data immediately via forwarding.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int    DEPTH     = 4,
  parameter int    ADDR_W    = 6,
  parameter int    WRITE_LAT = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_write,
  input  logic                    mem_read,
  input  logic [31:0]             addr,
  input  logic [31:0]             write_data,
  output logic [31:0]             read_data,
  output logic [$clog2(DEPTH):0]  sb_count,
  output logic                    sb_empty,
  output logic                    sb_full,
  output logic                    overflow
);

  localparam int SB_CNT_W = $clog2(DEPTH) + 1;
  localparam int CNT_W    = drain_cnt_w(WRITE_LAT);

  logic [31:0]           r_ram [2**ADDR_W];
  drain_state_t          r_state;
  logic [CNT_W-1:0]      r_lat_cnt;
  logic                  r_overflow;

  drain_state_t          w_state_next;
  logic [CNT_W-1:0]      w_lat_next;
  logic                  w_commit;
  logic                  w_push_ok;
  logic                  w_full;
  logic [SB_CNT_W-1:0]   w_count;
  logic [SB_INDEX_W-1:0] w_index;
  logic [SB_INDEX_W-1:0] w_head_index;
  logic [31:0]           w_head_data;
  logic                  w_hit;
  logic [31:0]           w_hit_data;
  logic [31:0]           w_ram_rdata;
  logic                  w_unused_bits;

  // Byte offset and address bits above the RAM are intentionally ignored.
  assign w_unused_bits = ^{addr[1:0], addr[31:ADDR_W+2],
                           w_head_index[SB_INDEX_W-1:ADDR_W]};

  assign w_index = {{(SB_INDEX_W-ADDR_W){1'b0}}, addr[ADDR_W+1:2]};

  // A push is taken when there is room, or when the head leaves this cycle.
  assign w_full    = (w_count == SB_CNT_W'(DEPTH));
  assign w_push_ok = mem_write && (!w_full || w_commit);

  sb_fifo #(
    .DEPTH(DEPTH)
  ) u_sb_fifo (
    .clk            (clk),
    .i_rst          (rst),
    .i_push         (w_push_ok),
    .i_push_index   (w_index),
    .i_push_data    (write_data),
    .i_pop          (w_commit),
    .i_lookup_index (w_index),
    .o_count        (w_count),
    .o_head_index   (w_head_index),
    .o_head_data    (w_head_data),
    .o_hit          (w_hit),
    .o_hit_data     (w_hit_data)
  );

  // RAM write port: only the drain commit writes; a reset on the commit
  // edge abandons the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      r_ram[w_head_index[ADDR_W-1:0]] <= w_head_data;
    end
  end

  // Asynchronous RAM read so loads complete in the same cycle.
  assign w_ram_rdata = r_ram[addr[ADDR_W+1:2]];

  // Load data: youngest buffered store to this word, else RAM.
  assign read_data = w_hit ? w_hit_data : w_ram_rdata;

  // Drain next-state: start only when no load is using the port this cycle;
  // once started, count down the write latency and commit on zero.
  always_comb begin
    w_state_next = r_state;
    w_lat_next   = r_lat_cnt;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if ((w_count != '0) && !mem_read) begin
          w_state_next = BUSY;
          w_lat_next   = CNT_W'(WRITE_LAT - 1);
        end
      end
      BUSY: begin
        if (r_lat_cnt != '0) begin
          w_lat_next = r_lat_cnt - CNT_W'(1);
        end else begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Drain state, latency counter and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_next;
      if (mem_write && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign sb_count = w_count;
  assign sb_empty = (w_count == '0);
  assign sb_full  = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer (DEPTH=4, ADDR_W=6, WRITE_LAT=2).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [2:0]  sb_count;
  logic        sb_empty;
  logic        sb_full;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  dmem_store_buffer #(
    .DEPTH(4), .ADDR_W(6), .WRITE_LAT(2), .INIT_FILE("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .sb_count   (sb_count),
    .sb_empty   (sb_empty),
    .sb_full    (sb_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one edge; returns 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One store cycle.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write  = 1'b1;
    mem_read   = 1'b0;
    addr       = a;
    write_data = d;
    tick();
    mem_write  = 1'b0;
  endtask

  // Combinational load probe without mem_read (does not block the drain).
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_eq(tag, read_data, exp);
  endtask

  // Idle until the buffer drains, bounded.
  task automatic wait_empty(input string tag);
    for (int i = 0; i < 64 && !sb_empty; i++) tick();
    check_eq(tag, 32'(sb_empty), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0; addr = '0; write_data = '0;
    tick(); tick();
    check_eq("rst_count", 32'(sb_count), 32'd0);
    check_eq("rst_empty", 32'(sb_empty), 32'd1);
    check_eq("rst_full",  32'(sb_full),  32'd0);
    check_eq("rst_ovf",   32'(overflow), 32'd0);
    rst = 1'b0;

    // Single store, forwarded load, then commit to RAM[4].
    store(32'h10, 32'hDEADBEEF);
    check_eq("t1_count_after_push", 32'(sb_count), 32'd1);
    mem_read = 1'b1; addr = 32'h10; #1;
    check_eq("t1_fwd", read_data, 32'hDEADBEEF);
    tick();                  // load blocks drain start on this edge
    mem_read = 1'b0;
    tick();                  // IDLE -> BUSY
    tick();                  // latency counter 1 -> 0
    check_eq("t1_count_pre_commit", 32'(sb_count), 32'd1);
    tick();                  // commit
    check_eq("t1_empty", 32'(sb_empty), 32'd1);
    peek("t1_ram4", 32'h10, 32'hDEADBEEF);

    // Same-address ordering: youngest forwarded, last write lands in RAM.
    store(32'h20, 32'd1);
    store(32'h20, 32'd2);
    store(32'h20, 32'd3);
    check_eq("t2_count", 32'(sb_count), 32'd3);
    mem_read = 1'b1; addr = 32'h20; #1;
    check_eq("t2_fwd_youngest", read_data, 32'd3);
    tick();
    mem_read = 1'b0;
    peek("t2_fwd_mid_drain", 32'h20, 32'd3);
    wait_empty("t2_drained");
    peek("t2_ram8", 32'h20, 32'd3);

    // A held load keeps the drain from starting.
    store(32'h30, 32'hA5A50001);
    for (int i = 0; i < 5; i++) begin
      mem_read = 1'b1; addr = 32'h30; #1;
      check_eq($sformatf("t3_hold_fwd%0d", i), read_data, 32'hA5A50001);
      check_eq($sformatf("t3_hold_cnt%0d", i), 32'(sb_count), 32'd1);
      tick();
    end
    mem_read = 1'b0;
    check_eq("t3_cnt_after_hold", 32'(sb_count), 32'd1);
    tick();                  // IDLE -> BUSY
    tick();                  // counter 1 -> 0
    check_eq("t3_cnt_pre_commit", 32'(sb_count), 32'd1);
    tick();                  // commit
    check_eq("t3_cnt_committed", 32'(sb_count), 32'd0);
    peek("t3_ram12", 32'h30, 32'hA5A50001);

    // Full boundary. Commits land on edges 3 and 6 counted from the first store.
    begin
      logic [31:0] exp_cnt [5] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd4};
      for (int i = 0; i < 5; i++) begin
        store(32'(i * 4), 32'h100 + 32'(i));
        check_eq($sformatf("t4_cnt%0d", i), 32'(sb_count), exp_cnt[i]);
      end
    end
    check_eq("t4_full",      32'(sb_full),  32'd1);
    check_eq("t4_no_ovf",    32'(overflow), 32'd0);
    tick();                  // edge 5: counter 1 -> 0, no commit yet
    store(32'h18, 32'h106);  // edge 6: commit and push together while full
    check_eq("t4_push_pop_cnt", 32'(sb_count), 32'd4);
    check_eq("t4_push_pop_ovf", 32'(overflow), 32'd0);
    store(32'h04, 32'hBAD);  // edge 7: full, drain only starting -> dropped
    check_eq("t4_drop_ovf", 32'(overflow), 32'd1);
    check_eq("t4_drop_cnt", 32'(sb_count), 32'd4);
    peek("t4_fwd_0x18",   32'h18, 32'h106);
    peek("t4_dropped_ram", 32'h04, 32'h101);
    tick();
    check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t4_rst_ovf", 32'(overflow), 32'd0);
    check_eq("t4_rst_cnt", 32'(sb_count), 32'd0);

    // Reset on the edge a commit would happen: old RAM word survives.
    store(32'h40, 32'h11111111);
    wait_empty("t5_first_drained");
    peek("t5_old", 32'h40, 32'h11111111);
    store(32'h40, 32'h22222222);
    tick();                  // IDLE -> BUSY
    tick();                  // counter 1 -> 0, commit pending
    peek("t5_fwd_new", 32'h40, 32'h22222222);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_empty", 32'(sb_empty), 32'd1);
    peek("t5_kept_old", 32'h40, 32'h11111111);
    tick(); tick(); tick();
    peek("t5_still_old", 32'h40, 32'h11111111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
